// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//   Shared constants for the iterative shifter/rotator (shift_unit) and its
//   combinational step stage (shift_step).
//   - OP_* : 3-bit operation codes presented on in_op.
//   - ST_* : FSM state encodings used by shift_unit.
//   Build option: SHIFT_UNIT_BARREL_EN (see shift_unit.sv).
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;  // result = operand
    localparam logic [2:0] OP_SLL  = 3'b001;  // shift left logical
    localparam logic [2:0] OP_SRL  = 3'b010;  // shift right logical
    localparam logic [2:0] OP_SRA  = 3'b011;  // shift right arithmetic
    localparam logic [2:0] OP_ROL  = 3'b100;  // rotate left
    localparam logic [2:0] OP_ROR  = 3'b101;  // rotate right
    localparam logic [2:0] OP_SIR  = 3'b110;  // shift right, serial-in fill
    localparam logic [2:0] OP_CLR  = 3'b111;  // result = 0

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
//   Purely combinational shift/rotate of a DATA_WIDTH value by k_i positions.
//   Used for one iteration (k <= STEP) or, in the barrel build, the whole
//   shift (k = amt).
//   Ports:
//     data_i  [DATA_WIDTH-1:0]  value to shift
//     op_i    [2:0]             operation code (shift_pkg::OP_*)
//     k_i     [KW-1:0]          shift distance, 0..DATA_WIDTH-1
//     fill_i                    bit shifted into vacated MSBs for SRA/SIR
//     data_o  [DATA_WIDTH-1:0]  shifted value
// ---------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KW         = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [2:0]            op_i,
    input  logic [KW-1:0]         k_i,
    input  logic                  fill_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [2*DATA_WIDTH-1:0] dbl;
    logic [2*DATA_WIDTH-1:0] dbl_left;
    logic [2*DATA_WIDTH-1:0] dbl_right;
    logic [DATA_WIDTH-1:0]   fill_mask;

    // Rotates: shifting a doubled copy brings the wrapped-out bits back in.
    assign dbl       = {data_i, data_i};
    assign dbl_left  = dbl << k_i;
    assign dbl_right = dbl >> k_i;

    // Ones in the k_i vacated MSB positions of a right shift.
    assign fill_mask = ~({DATA_WIDTH{1'b1}} >> k_i);

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_LOAD: data_o = data_i;
            OP_SLL:  data_o = data_i << k_i;
            OP_SRL:  data_o = data_i >> k_i;
            OP_SRA,
            OP_SIR:  data_o = (data_i >> k_i) | (fill_i ? fill_mask : '0);
            OP_ROL:  data_o = dbl_left[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_ROR:  data_o = dbl_right[DATA_WIDTH-1:0];
            OP_CLR:  data_o = '0;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
//   Handshaked shifter/rotator. A request (operand, op, amount, serial bit)
//   is taken on the in_* valid/ready port, shifted STEP bits per cycle, and
//   the result is held on the out_* valid/ready port until consumed. Only one
//   operation is in flight; in_ready is low from acceptance until the cycle
//   after the output handshake.
//   Ports:
//     clk, rst (synchronous, active-high)
//     in_valid/in_ready, in_data[DATA_WIDTH], in_op[3],
//     in_amt[$clog2(DATA_WIDTH)], in_sin
//     out_valid/out_ready, out_data[DATA_WIDTH]
//   Build option:
//     SHIFT_UNIT_BARREL_EN - when defined every op completes in one cycle via
//     a full-width shift_step; STEP is then unused.
// ---------------------------------------------------------------------------
module shift_unit
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STEP       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [2:0]                    in_op,
    input  logic [$clog2(DATA_WIDTH)-1:0] in_amt,
    input  logic                          in_sin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data
);

    localparam int AW = $clog2(DATA_WIDTH);
    // STEP can equal DATA_WIDTH, which needs one bit more than the amount.
    localparam logic [AW:0] STEP_W = (AW + 1)'(STEP);

    logic [1:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] work_q,   work_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [2:0]            op_q,     op_d;
    logic [AW-1:0]         rem_q,    rem_d;
    logic                  fill_q,   fill_d;

    logic                  accept;
    logic                  in_fill;
    logic                  skip_shift;
    logic [AW-1:0]         k_shift;
    logic                  in_idle;
    logic [DATA_WIDTH-1:0] step_in;
    logic [2:0]            step_op;
    logic [AW-1:0]         step_k;
    logic                  step_fill;
    logic [DATA_WIDTH-1:0] step_out;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_ready  = in_idle && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = result_q;

    // Arithmetic fill is frozen to the operand MSB at capture time.
    assign in_fill = (in_op == OP_SRA) ? in_data[DATA_WIDTH-1] : in_sin;

`ifdef SHIFT_UNIT_BARREL_EN
    assign skip_shift = 1'b1;
`else
    assign skip_shift = (in_op == OP_LOAD) || (in_op == OP_CLR) || (in_amt == '0);
`endif

    // k = min(STEP, remaining); remaining < DATA_WIDTH so k fits in AW bits.
    assign k_shift = ({1'b0, rem_q} > STEP_W) ? STEP_W[AW-1:0] : rem_q;

    // While idle the step stage sees the incoming request directly (full
    // amount), which produces the one-cycle result for zero-shift ops and for
    // the barrel build. Otherwise it iterates on the working register.
    assign step_in   = in_idle ? in_data : work_q;
    assign step_op   = in_idle ? in_op   : op_q;
    assign step_k    = in_idle ? in_amt  : k_shift;
    assign step_fill = in_idle ? in_fill : fill_q;

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .KW         (AW)
    ) u_step (
        .data_i (step_in),
        .op_i   (step_op),
        .k_i    (step_k),
        .fill_i (step_fill),
        .data_o (step_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        op_d     = op_q;
        rem_d    = rem_q;
        fill_d   = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = in_op;
                    fill_d = in_fill;
                    work_d = in_data;
                    if (skip_shift) begin
                        result_d = step_out;
                        rem_d    = '0;
                        state_d  = ST_DONE;
                    end else begin
                        rem_d   = in_amt;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                rem_d = rem_q - k_shift;
                if (rem_q == k_shift) begin
                    result_d = step_out;
                    state_d  = ST_DONE;
                end else begin
                    work_d = step_out;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= '0;
            op_q     <= OP_LOAD;
            rem_q    <= '0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_unit
//   Two 8-bit instances (STEP=1 and STEP=4) each driven by a directed table
//   followed by random requests. Expected results and latencies come from a
//   bit-level reference model and are queued at acceptance; a per-instance
//   monitor pops and compares when out_valid rises, and checks hold/stability
//   and the ready-after-handshake rule every cycle.
// ---------------------------------------------------------------------------
module tb_shift_unit;

    localparam int DW = 8;
    localparam int NT = 58;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input bit ok, input int lane, input string name,
                         input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL lane%0d %s actual=0x%0h expected=0x%0h", lane, name, act, exp);
        end
    endtask

    // Reference: each result bit located directly from the op definition.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [2:0] op,
                                            input int amt, input logic sin);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            case (op)
                3'd0: r[i] = d[i];
                3'd1: r[i] = (i - amt >= 0) ? d[i - amt] : 1'b0;
                3'd2: r[i] = (i + amt < DW) ? d[i + amt] : 1'b0;
                3'd3: r[i] = (i + amt < DW) ? d[i + amt] : d[DW-1];
                3'd4: r[i] = d[(i - amt + DW) % DW];
                3'd5: r[i] = d[(i + amt) % DW];
                3'd6: r[i] = (i + amt < DW) ? d[i + amt] : sin;
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic int latency(input logic [2:0] op, input int amt, input int step);
`ifdef SHIFT_UNIT_BARREL_EN
        return 0;
`else
        if (op == 3'd0 || op == 3'd7) return 0;
        return (amt + step - 1) / step;
`endif
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            accept_cyc;
        int            lat;
    } exp_t;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int STEP_L = (gi == 0) ? 1 : 4;

        logic          rst;
        logic          in_valid, in_ready, in_sin;
        logic [DW-1:0] in_data;
        logic [2:0]    in_op;
        logic [2:0]    in_amt;
        logic          out_valid, out_ready;
        logic [DW-1:0] out_data;

        exp_t          q[$];
        int            cyc = 0;
        logic [DW-1:0] last_res = '0;
        bit            mon_en = 1'b0;
        bit            done_l = 1'b0;

        logic [2:0]    d_op   [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd7, 3'd1, 3'd0};
        logic [DW-1:0] d_data [8] = '{8'h90, 8'h81, 8'h01, 8'h00, 8'hA5, 8'hFF, 8'h01, 8'h3C};
        logic [2:0]    d_amt  [8] = '{3'd3, 3'd1, 3'd7, 3'd3, 3'd0, 3'd5, 3'd7, 3'd6};
        logic          d_sin  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        shift_unit #(
            .DATA_WIDTH (DW),
            .STEP       (STEP_L)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_op     (in_op),
            .in_amt    (in_amt),
            .in_sin    (in_sin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Consumer: random acceptance with occasional 5-cycle stalls; changes
        // just after the rising edge so it is stable at the sampling edge.
        initial begin
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #2;
                if ($urandom_range(0, 7) == 0) begin
                    out_ready = 1'b0;
                    repeat (5) @(posedge clk);
                    #2;
                end
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end

        // Driver
        initial begin
            logic [2:0]    op;
            logic [DW-1:0] d;
            logic [2:0]    amt;
            logic          sin;
            int            w;
            rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; in_sin = 1'b0;
            repeat (3) @(negedge clk);
            check(out_valid == 1'b0, gi, "rst_out_valid", int'(out_valid), 0);
            check(out_data == '0, gi, "rst_out_data", int'(out_data), 0);
            check(in_ready == 1'b0, gi, "rst_in_ready", int'(in_ready), 0);
            rst = 1'b0;
            @(negedge clk);
            check(in_ready == 1'b1, gi, "post_rst_in_ready", int'(in_ready), 1);
            mon_en = 1'b1;

            for (int i = 0; i <= NT; i++) begin
                if (i == NT) begin
                    // Drain, then abort an amt=6 shift with rst two edges after acceptance.
                    w = 0;
                    while ((q.size() != 0 || !in_ready) && w < 500) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                        w++;
                    end
                    check(w < 500, gi, "drain_timeout", w, 500);
                    mon_en = 1'b0;
                    in_valid = 1'b1; in_op = 3'd1; in_data = 8'h5A; in_amt = 3'd6; in_sin = 1'b0;
                    @(negedge clk);
                    in_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    check(out_valid == 1'b0, gi, "abort_out_valid", int'(out_valid), 0);
                    check(out_data == '0, gi, "abort_out_data", int'(out_data), 0);
                    check(in_ready == 1'b0, gi, "abort_in_ready", int'(in_ready), 0);
                    rst = 1'b0;
                    @(negedge clk);
                    check(in_ready == 1'b1, gi, "abort_recover_ready", int'(in_ready), 1);
                    mon_en = 1'b1;
                end
                if (i < 8) begin
                    op = d_op[i]; d = d_data[i]; amt = d_amt[i]; sin = d_sin[i];
                end else begin
                    op = 3'($urandom_range(0, 7)); d = 8'($urandom);
                    amt = 3'($urandom_range(0, 7)); sin = 1'($urandom);
                end
                // Junk requests while busy must be ignored.
                w = 0;
                while (!in_ready && w < 300) begin
                    in_valid = 1'($urandom);
                    in_data = 8'($urandom); in_op = 3'($urandom); in_amt = 3'($urandom);
                    in_sin = 1'($urandom);
                    @(negedge clk);
                    w++;
                end
                check(w < 300, gi, "in_ready_timeout", w, 300);
                in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt; in_sin = sin;
                q.push_back('{model(d, op, int'(amt), sin), cyc + 1,
                              latency(op, int'(amt), STEP_L)});
                @(negedge clk);
                in_valid = 1'b0;
            end
            w = 0;
            while (q.size() != 0 && w < 500) begin
                @(negedge clk);
                w++;
            end
            check(w < 500, gi, "final_drain_timeout", w, 500);
            done_l = 1'b1;
        end

        // Monitor
        initial begin
            bit   prev_valid = 1'b0;
            bit   prev_hs    = 1'b0;
            exp_t e;
            forever begin
                @(negedge clk);
                if (!mon_en || rst) begin
                    prev_valid = 1'b0;
                    prev_hs    = 1'b0;
                    last_res   = '0;
                end else begin
                    if (prev_hs) begin
                        check(in_ready == 1'b1, gi, "ready_after_hs", int'(in_ready), 1);
                        check(out_valid == 1'b0, gi, "valid_drop_after_hs", int'(out_valid), 0);
                    end
                    if (out_valid && !prev_valid) begin
                        if (q.size() == 0) begin
                            check(1'b0, gi, "unexpected_out_valid", int'(out_data), 0);
                        end else begin
                            e = q.pop_front();
                            check(out_data == e.data, gi, "result", int'(out_data), int'(e.data));
                            check(cyc == e.accept_cyc + e.lat, gi, "latency",
                                  cyc - e.accept_cyc, e.lat);
                            $display("TXN lane%0d result=0x%02h expected=0x%02h lat=%0d",
                                     gi, out_data, e.data, e.lat);
                            last_res = e.data;
                        end
                    end else if (out_valid) begin
                        check(out_data == last_res, gi, "done_stable", int'(out_data), int'(last_res));
                    end else begin
                        check(out_data == last_res, gi, "idle_hold", int'(out_data), int'(last_res));
                    end
                    if (out_valid) begin
                        check(in_ready == 1'b0, gi, "no_overlap", int'(in_ready), 0);
                    end
                    prev_valid = out_valid;
                    prev_hs    = out_valid && out_ready;
                end
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_lane[0].done_l && g_lane[1].done_l) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check(t < 60000, -1, "global_timeout", t, 60000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
